// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: one requester's op request and result response handshakes
interface alu_share_arbiter_if #(
  parameter int DW  = 32,
  parameter int OPW = 3
);
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic [DW-1:0]  req_a;
  logic [DW-1:0]  req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_zero;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters, one op in flight
module alu_share_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  r0_io,
  alu_share_arbiter_if.slave  r1_io,
  output logic [OPW-1:0]      alu_op_o,
  output logic [DW-1:0]       alu_num1_o,
  output logic [DW-1:0]       alu_num2_o,
  input  logic [DW-1:0]       alu_result_i,
  input  logic                alu_zero_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t         state_q;
  logic           last_q, owner_q, rv0_q, rv1_q, zero_q;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q, b_q, res_q;
  logic           gnt, acc;
  // On a tie the requester that did not win last time goes next
  assign gnt = (r0_io.req_valid && r1_io.req_valid) ? !last_q : r1_io.req_valid;
  assign r0_io.req_ready = state_q == IDLE && !rst && r0_io.req_valid && !gnt;
  assign r1_io.req_ready = state_q == IDLE && !rst && r1_io.req_valid && gnt;
  assign acc = r0_io.req_ready || r1_io.req_ready;
  assign alu_op_o   = op_q;
  assign alu_num1_o = a_q;
  assign alu_num2_o = b_q;
  assign r0_io.rsp_valid  = rv0_q;
  assign r0_io.rsp_result = res_q;
  assign r0_io.rsp_zero   = zero_q;
  assign r1_io.rsp_valid  = rv1_q;
  assign r1_io.rsp_result = res_q;
  assign r1_io.rsp_zero   = zero_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (acc) begin
          state_q <= EXEC;
          owner_q <= gnt;
          last_q  <= gnt;
          op_q    <= gnt ? r1_io.req_op : r0_io.req_op;
          a_q     <= gnt ? r1_io.req_a : r0_io.req_a;
          b_q     <= gnt ? r1_io.req_b : r0_io.req_b;
        end
        EXEC: begin
          state_q <= RESP;
          res_q   <= alu_result_i;
          zero_q  <= alu_zero_i;
          rv0_q   <= !owner_q;
          rv1_q   <= owner_q;
        end
        RESP: if (owner_q ? r1_io.rsp_ready : r0_io.rsp_ready) begin
          state_q <= IDLE;
          rv0_q   <= 1'b0;
          rv1_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a round-robin reference model and an ALU stand-in
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_share_arbiter_if #(.DW(32), .OPW(3)) p0 ();
  alu_share_arbiter_if #(.DW(32), .OPW(3)) p1 ();
  logic [2:0]  alu_op;
  logic [31:0] alu_n1, alu_n2, alu_res;
  logic        alu_z;
  logic        v[2], rr[2];
  logic [2:0]  op[2];
  logic [31:0] a[2], b[2];
  assign p0.req_valid = v[0];
  assign p0.req_op    = op[0];
  assign p0.req_a     = a[0];
  assign p0.req_b     = b[0];
  assign p0.rsp_ready = rr[0];
  assign p1.req_valid = v[1];
  assign p1.req_op    = op[1];
  assign p1.req_a     = a[1];
  assign p1.req_b     = b[1];
  assign p1.rsp_ready = rr[1];
  alu_share_arbiter #(.DW(32), .OPW(3)) dut (
    .clk(clk), .rst(rst), .r0_io(p0), .r1_io(p1),
    .alu_op_o(alu_op), .alu_num1_o(alu_n1), .alu_num2_o(alu_n2),
    .alu_result_i(alu_res), .alu_zero_i(alu_z)
  );
  function automatic logic [31:0] alu_f(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return ~x;
      3'd5: return {31'd0, x < y};
      default: return 32'd0;
    endcase
  endfunction
  always_comb begin
    alu_res = alu_f(alu_op, alu_n1, alu_n2);
    alu_z   = alu_res == 32'd0;
  end
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] q0[$], q1[$];
  logic busy = 1'b0, last = 1'b1, own = 1'b0, seen = 1'b0, stop = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [1:0]  rv, rd, vv, om;
    logic        w;
    logic [31:0] e;
    rv = {p1.rsp_valid, p0.rsp_valid};
    rd = {p1.req_ready, p0.req_ready};
    vv = {p1.req_valid, p0.req_valid};
    if (rst) begin
      chk("rst_ready", 32'(rd), 32'd0);
      q0.delete();
      q1.delete();
      busy = 1'b0;
      last = 1'b1;
      seen = 1'b0;
    end else begin
      om = busy ? (own ? 2'b10 : 2'b01) : 2'b00;
      chk("rsp_unexp", 32'(rv & ~om), 32'd0);
      if (busy) begin
        chk("ready_busy", 32'(rd), 32'd0);
        if (rv[own]) begin
          e = own ? q1[0] : q0[0];
          chk("rsp_result", own ? p1.rsp_result : p0.rsp_result, e);
          chk("rsp_zero", 32'(own ? p1.rsp_zero : p0.rsp_zero), 32'(e == 32'd0));
          if (!seen) chk("latency", 32'(cyc - acc_cyc), 32'd2);
          seen = 1'b1;
          if (rr[own]) begin
            if (own) void'(q1.pop_front());
            else void'(q0.pop_front());
            busy = 1'b0;
          end
        end else if (seen || cyc > acc_cyc + 2) begin
          chk("rsp_missing", 32'd0, 32'd1);
          q0.delete();
          q1.delete();
          busy = 1'b0;
        end
      end else if (vv != 2'b00) begin
        w = (vv == 2'b11) ? !last : vv[1];
        chk("grant", 32'(rd), w ? 32'd2 : 32'd1);
        e = alu_f(op[w], a[w], b[w]);
        if (w) q1.push_back(e);
        else q0.push_back(e);
        busy = 1'b1;
        last = w;
        own = w;
        acc_cyc = cyc;
        seen = 1'b0;
      end else chk("ready_idle", 32'(rd), 32'd0);
    end
  end
  task automatic issue(input int n, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int maxw);
    logic acc = 1'b0;
    op[n] = o;
    a[n] = x;
    b[n] = y;
    v[n] = 1'b1;
    for (int k = 0; k < maxw && !acc; k++) begin
      @(negedge clk);
      acc = (n != 0) ? p1.req_ready : p0.req_ready;
      @(posedge clk);
      #1;
    end
    v[n] = 1'b0;
    if (maxw > 1 && !acc) chk("req_timeout", 32'd0, 32'd1);
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 60 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic rand_drv(input int n, input int cnt);
    logic [31:0] x, y;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      issue(n, 3'($urandom_range(0, 7)), x, y, ($urandom_range(0, 4) == 0) ? 1 : 200);
    end
  endtask
  logic [2:0]  t_op[6] = '{3'd5, 3'd5, 3'd5, 3'd4, 3'd6, 3'd7};
  logic [31:0] t_a[6]  = '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd5};
  logic [31:0] t_b[6]  = '{32'd2, 32'd1, 32'd1, 32'd0, 32'd4, 32'd6};
  initial begin
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
    op[0] = 0; op[1] = 0; a[0] = 0; a[1] = 0; b[0] = 0; b[1] = 0;
    do_reset();
    @(negedge clk);
    chk("rst_rsp0_valid", 32'(p0.rsp_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(p1.rsp_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_num1", alu_n1, 32'd0);
    chk("rst_alu_num2", alu_n2, 32'd0);
    chk("rst_rsp_result", p0.rsp_result, 32'd0);
    chk("rst_rsp_zero", 32'(p1.rsp_zero), 32'd0);
    @(posedge clk);
    #1;
    issue(0, 3'd0, 32'd5, 32'd7, 200);
    wait_idle();
    do_reset();
    fork
      issue(0, 3'd1, 32'd3, 32'd3, 200);
      issue(1, 3'd2, 32'hF0, 32'h0F, 200);
    join
    wait_idle();
    fork
      for (int i = 0; i < 3; i++) issue(0, 3'd0, 32'(i), 32'd100, 200);
      for (int i = 0; i < 3; i++) issue(1, 3'd3, 32'(i), 32'h80, 200);
    join
    wait_idle();
    rr[1] = 1'b0;
    fork
      begin
        issue(1, 3'd3, 32'd1, 32'd2, 200);
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        rr[1] = 1'b1;
      end
      begin
        @(posedge clk);
        #1;
        issue(0, 3'd0, 32'd9, 32'd9, 200);
      end
    join
    wait_idle();
    issue(0, 3'd0, 32'd4, 32'd4, 200);
    rst = 1'b1;
    v[0] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    v[0] = 1'b0;
    @(negedge clk);
    chk("rst_drop_valid", 32'({p1.rsp_valid, p0.rsp_valid}), 32'd0);
    @(posedge clk);
    #1;
    issue(0, 3'd0, 32'd10, 32'd20, 200);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      issue(i % 2, t_op[i], t_a[i], t_b[i], 200);
      wait_idle();
    end
    fork
      begin
        fork
          rand_drv(0, 40);
          rand_drv(1, 40);
        join
        stop = 1'b1;
      end
      while (!stop) begin
        @(posedge clk);
        #1;
        rr[0] = 1'($urandom_range(0, 1));
        rr[1] = 1'($urandom_range(0, 1));
      end
    join
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    wait_idle();
    chk("final_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
